// File: rtl/udm_host.sv
// udm_host: initiator for the UDM UART debug protocol.
// Turns single-word bus requests into escaped UDM command frames for a UART TX
// core and parses the slave's byte responses from a UART RX core.
// Optional build macro UDM_HOST_SYNC_EN: prefix each frame with one unescaped 0x55.
module udm_host #(
    parameter int unsigned RESP_TIMEOUT = 1048576
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_bi,
    input  logic [31:0] host_wdata_bi,
    output logic        host_ack_o,
    output logic        host_resp_o,
    output logic        host_err_o,
    output logic [1:0]  host_err_code_bo,
    output logic [31:0] host_rdata_bo,
    output logic        irq_o,
    output logic [7:0]  tx_dout_bo,
    output logic        tx_start_o,
    input  logic        tx_done_tick_i,
    input  logic        rx_done_tick_i,
    input  logic [7:0]  rx_din_bi
);

    localparam int unsigned TW = $clog2(RESP_TIMEOUT + 2);
    localparam int unsigned IW = 4;

    localparam logic [7:0] SYNC     = 8'h55;
    localparam logic [7:0] ESC      = 8'h5A;
    localparam logic [7:0] CMD_WR   = 8'h83;
    localparam logic [7:0] CMD_RD   = 8'h84;
    localparam logic [7:0] WR_SUCC  = 8'h00;
    localparam logic [7:0] ERR_ACK  = 8'h01;
    localparam logic [7:0] ERR_RESP = 8'h02;
    localparam logic [7:0] IRQ      = 8'h80;

`ifdef UDM_HOST_SYNC_EN
    localparam int unsigned SYNC_LEN = 1;
`else
    localparam int unsigned SYNC_LEN = 0;
`endif

    // Index of the last frame byte (sync prefix included when present)
    localparam logic [IW-1:0] LAST_RD = IW'(8 + SYNC_LEN);
    localparam logic [IW-1:0] LAST_WR = IW'(12 + SYNC_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TX_SEND,
        S_TX_WAIT,
        S_RX_WAIT
    } state_t;

    state_t          state_q, state_n;
    logic            we_q, we_n;
    logic [31:0]     addr_q, addr_n;
    logic [31:0]     wdata_q, wdata_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic            esc_tx_q, esc_tx_n;
    logic            esc_rx_q, esc_rx_n;
    logic [1:0]      rd_cnt_q, rd_cnt_n;
    logic [23:0]     rd_sh_q, rd_sh_n;
    logic [TW-1:0]   tmo_q, tmo_n;

    logic            ack_n, resp_n, err_n, irq_n, start_n;
    logic [1:0]      code_n;
    logic [31:0]     rdata_n;
    logic [7:0]      dout_n;

    logic [IW-1:0]   fidx_c;
    logic            is_sync_c;
    logic [7:0]      fbyte_c;
    logic            need_esc_c;
    logic [IW-1:0]   last_c;
    logic            fin_c;
    logic [1:0]      fin_code_c;
    logic            data_c;

    // Logical frame byte at the current index and whether it needs an escape prefix
    always_comb begin
`ifdef UDM_HOST_SYNC_EN
        is_sync_c = (idx_q == '0);
        fidx_c    = idx_q - IW'(1);
`else
        is_sync_c = 1'b0;
        fidx_c    = idx_q;
`endif
        fbyte_c = 8'h00;
        case (fidx_c)
            4'd0:    fbyte_c = we_q ? CMD_WR : CMD_RD;
            4'd1:    fbyte_c = addr_q[7:0];
            4'd2:    fbyte_c = addr_q[15:8];
            4'd3:    fbyte_c = addr_q[23:16];
            4'd4:    fbyte_c = addr_q[31:24];
            4'd5:    fbyte_c = 8'h04;
            4'd9:    fbyte_c = wdata_q[7:0];
            4'd10:   fbyte_c = wdata_q[15:8];
            4'd11:   fbyte_c = wdata_q[23:16];
            4'd12:   fbyte_c = wdata_q[31:24];
            default: fbyte_c = 8'h00;
        endcase
        if (is_sync_c) begin
            fbyte_c = SYNC;
        end
        need_esc_c = !is_sync_c && ((fbyte_c == SYNC) || (fbyte_c == ESC));
        last_c     = we_q ? LAST_WR : LAST_RD;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_q;
        we_n       = we_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        idx_n      = idx_q;
        esc_tx_n   = esc_tx_q;
        esc_rx_n   = esc_rx_q;
        rd_cnt_n   = rd_cnt_q;
        rd_sh_n    = rd_sh_q;
        tmo_n      = tmo_q;
        ack_n      = 1'b0;
        resp_n     = 1'b0;
        err_n      = 1'b0;
        code_n     = 2'd0;
        irq_n      = 1'b0;
        start_n    = 1'b0;
        rdata_n    = host_rdata_bo;
        dout_n     = tx_dout_bo;
        fin_c      = 1'b0;
        fin_code_c = 2'd0;
        data_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_req_i) begin
                    we_n     = host_we_i;
                    addr_n   = host_addr_bi;
                    wdata_n  = host_wdata_bi;
                    idx_n    = '0;
                    esc_tx_n = 1'b0;
                    esc_rx_n = 1'b0;
                    rd_cnt_n = 2'd0;
                    tmo_n    = '0;
                    ack_n    = 1'b1;
                    state_n  = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                start_n = 1'b1;
                dout_n  = (need_esc_c && !esc_tx_q) ? ESC : fbyte_c;
                state_n = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_done_tick_i) begin
                    if (need_esc_c && !esc_tx_q) begin
                        esc_tx_n = 1'b1;
                        state_n  = S_TX_SEND;
                    end else if (idx_q == last_c) begin
                        esc_tx_n = 1'b0;
                        tmo_n    = '0;
                        state_n  = S_RX_WAIT;
                    end else begin
                        esc_tx_n = 1'b0;
                        idx_n    = idx_q + IW'(1);
                        state_n  = S_TX_SEND;
                    end
                end
            end
            S_RX_WAIT: begin
                if (rx_done_tick_i) begin
                    tmo_n = '0;
                    if (esc_rx_q) begin
                        esc_rx_n = 1'b0;
                        data_c   = 1'b1;
                    end else begin
                        case (rx_din_bi)
                            ESC:      esc_rx_n = 1'b1;
                            IRQ:      irq_n = 1'b1;
                            ERR_ACK:  begin fin_c = 1'b1; fin_code_c = 2'd1; end
                            ERR_RESP: begin fin_c = 1'b1; fin_code_c = 2'd2; end
                            SYNC:     begin end
                            default:  data_c = 1'b1;
                        endcase
                    end
                    if (data_c) begin
                        if (we_q) begin
                            fin_c      = 1'b1;
                            fin_code_c = (!esc_rx_q && (rx_din_bi == WR_SUCC)) ? 2'd0 : 2'd3;
                        end else begin
                            rd_sh_n = {rx_din_bi, rd_sh_q[23:8]};
                            if (rd_cnt_q == 2'd3) begin
                                rdata_n    = {rx_din_bi, rd_sh_q};
                                fin_c      = 1'b1;
                                fin_code_c = 2'd0;
                            end else begin
                                rd_cnt_n = rd_cnt_q + 2'd1;
                            end
                        end
                    end
                end else if (tmo_q > TW'(RESP_TIMEOUT)) begin
                    fin_c      = 1'b1;
                    fin_code_c = 2'd3;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (fin_c) begin
            resp_n  = 1'b1;
            err_n   = (fin_code_c != 2'd0);
            code_n  = fin_code_c;
            state_n = S_IDLE;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q          <= S_IDLE;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            idx_q            <= '0;
            esc_tx_q         <= 1'b0;
            esc_rx_q         <= 1'b0;
            rd_cnt_q         <= 2'd0;
            rd_sh_q          <= '0;
            tmo_q            <= '0;
            host_ack_o       <= 1'b0;
            host_resp_o      <= 1'b0;
            host_err_o       <= 1'b0;
            host_err_code_bo <= 2'd0;
            host_rdata_bo    <= '0;
            irq_o            <= 1'b0;
            tx_dout_bo       <= '0;
            tx_start_o       <= 1'b0;
        end else begin
            state_q          <= state_n;
            we_q             <= we_n;
            addr_q           <= addr_n;
            wdata_q          <= wdata_n;
            idx_q            <= idx_n;
            esc_tx_q         <= esc_tx_n;
            esc_rx_q         <= esc_rx_n;
            rd_cnt_q         <= rd_cnt_n;
            rd_sh_q          <= rd_sh_n;
            tmo_q            <= tmo_n;
            host_ack_o       <= ack_n;
            host_resp_o      <= resp_n;
            host_err_o       <= err_n;
            host_err_code_bo <= code_n;
            host_rdata_bo    <= rdata_n;
            irq_o            <= irq_n;
            tx_dout_bo       <= dout_n;
            tx_start_o       <= start_n;
        end
    end

endmodule

// File: tb/tb_udm_host.sv
// Self-checking bench for udm_host: UART TX core model, UDM slave response
// encoder and a frame-level reference model of the host's TX stream.
module tb_udm_host;

    localparam int unsigned TMO = 16;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        host_req_i = 1'b0;
    logic        host_we_i = 1'b0;
    logic [31:0] host_addr_bi = '0;
    logic [31:0] host_wdata_bi = '0;
    logic        host_ack_o, host_resp_o, host_err_o;
    logic [1:0]  host_err_code_bo;
    logic [31:0] host_rdata_bo;
    logic        irq_o;
    logic [7:0]  tx_dout_bo;
    logic        tx_start_o;
    logic        tx_done_tick_i = 1'b0;
    logic        rx_done_tick_i = 1'b0;
    logic [7:0]  rx_din_bi = '0;

    udm_host #(.RESP_TIMEOUT(TMO)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .host_req_i       (host_req_i),
        .host_we_i        (host_we_i),
        .host_addr_bi     (host_addr_bi),
        .host_wdata_bi    (host_wdata_bi),
        .host_ack_o       (host_ack_o),
        .host_resp_o      (host_resp_o),
        .host_err_o       (host_err_o),
        .host_err_code_bo (host_err_code_bo),
        .host_rdata_bo    (host_rdata_bo),
        .irq_o            (irq_o),
        .tx_dout_bo       (tx_dout_bo),
        .tx_start_o       (tx_start_o),
        .tx_done_tick_i   (tx_done_tick_i),
        .rx_done_tick_i   (rx_done_tick_i),
        .rx_din_bi        (rx_din_bi)
    );

    always #5 clk_i = ~clk_i;

    int ncmp = 0;
    int nfail = 0;

    logic [7:0] tx_cap[$];
    logic [7:0] last_tx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_q[$];
    bit         tx_busy = 1'b0;
    int         tx_viol = 0;

    int          cyc = 0;
    int          resp_cnt = 0, irq_cnt = 0, ack_cnt = 0, resp_cyc = 0;
    logic        cap_err = 1'b0;
    logic [1:0]  cap_code = 2'd0;
    logic [31:0] exp_rdata = '0;
    int          ack_base = 0;

`ifdef UDM_HOST_SYNC_EN
    localparam int SO = 1;
`else
    localparam int SO = 0;
`endif

    // Pulse monitor: counts host-side pulses and captures resp payload
    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (host_resp_o) begin
            resp_cnt <= resp_cnt + 1;
            resp_cyc <= cyc + 1;
            cap_err  <= host_err_o;
            cap_code <= host_err_code_bo;
        end
        if (irq_o)      irq_cnt <= irq_cnt + 1;
        if (host_ack_o) ack_cnt <= ack_cnt + 1;
    end

    // UART TX core model: one byte in flight, done tick after a few cycles
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_start_o) begin
                tx_cap.push_back(tx_dout_bo);
                tx_busy = 1'b1;
                repeat (2 + $urandom_range(2)) begin
                    @(negedge clk_i);
                    if (tx_start_o) tx_viol++;
                end
                tx_done_tick_i = 1'b1;
                @(negedge clk_i);
                if (tx_start_o) tx_viol++;
                tx_done_tick_i = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", ncmp, nfail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: logical bytes, then byte-stuffing of 0x55/0x5A
    task automatic build_frame(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] lg[$];
        lg.delete();
        exp_tx.delete();
        lg.push_back(we ? 8'h83 : 8'h84);
        for (int i = 0; i < 4; i++) lg.push_back(a[8*i +: 8]);
        lg.push_back(8'h04);
        for (int i = 0; i < 3; i++) lg.push_back(8'h00);
        if (we) for (int i = 0; i < 4; i++) lg.push_back(d[8*i +: 8]);
        if (SO == 1) exp_tx.push_back(8'h55);
        foreach (lg[i]) begin
            if (lg[i] == 8'h55 || lg[i] == 8'h5A) exp_tx.push_back(8'h5A);
            exp_tx.push_back(lg[i]);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(7))
            0: return 8'h55;
            1: return 8'h5A;
            2: return 8'h80;
            3: return 8'h01;
            4: return 8'h02;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        return {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    endfunction

    // Slave-side noise between response bytes: irq markers and stray syncs
    task automatic add_noise(inout int irqs);
        repeat ($urandom_range(2)) begin
            if ($urandom_range(1) == 1) begin
                rx_q.push_back(8'h80);
                irqs++;
            end else begin
                rx_q.push_back(8'h55);
            end
        end
    endtask

    // Slave read payload: LSB first, control-looking bytes escaped
    task automatic enc_read(input logic [31:0] w, inout int irqs);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            add_noise(irqs);
            b = w[8*i +: 8];
            if (b == 8'h55 || b == 8'h5A || b == 8'h80 || b == 8'h01 || b == 8'h02 ||
                $urandom_range(7) == 0)
                rx_q.push_back(8'h5A);
            rx_q.push_back(b);
        end
    endtask

    task automatic rx_send(input logic [7:0] b);
        repeat ($urandom_range(2)) tick();
        rx_din_bi = b;
        rx_done_tick_i = 1'b1;
        tick();
        rx_done_tick_i = 1'b0;
        rx_din_bi = 8'($urandom);
    endtask

    task automatic xfer_start(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input bit hold, input bit inject);
        bit got;
        got = 1'b0;
        build_frame(we, a, d);
        tx_cap.delete();
        ack_base = ack_cnt;
        host_we_i = we;
        host_addr_bi = a;
        host_wdata_bi = d;
        host_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_cnt != ack_base) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_seen", 64'(got), 64'd1);
        chk("ack_single", 64'(ack_cnt - ack_base), 64'd1);
        if (!hold) host_req_i = 1'b0;
        if (inject) begin
            rx_din_bi = 8'h01;
            rx_done_tick_i = 1'b1;
            tick();
            rx_done_tick_i = 1'b0;
        end
    endtask

    task automatic xfer_finish(input string tag, input logic we, input logic [1:0] exp_code,
                               input int exp_irq, input logic [31:0] word, input bit silent);
        bit got;
        int irq_base, resp_base, c0, okb;
        irq_base = irq_cnt;
        resp_base = resp_cnt;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_cap.size() >= exp_tx.size() && !tx_busy) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_tx_done"}, 64'(got), 64'd1);
        chk({tag, "_tx_len"}, 64'(tx_cap.size()), 64'(exp_tx.size()));
        okb = 1;
        foreach (exp_tx[i]) if (i >= tx_cap.size() || tx_cap[i] !== exp_tx[i]) okb = 0;
        chk({tag, "_tx_bytes"}, 64'(okb), 64'd1);
        c0 = cyc;
        foreach (rx_q[i]) rx_send(rx_q[i]);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_cnt != resp_base) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        last_tx = tx_cap;
        tx_cap.delete();
        chk({tag, "_resp_seen"}, 64'(got), 64'd1);
        chk({tag, "_resp_single"}, 64'(resp_cnt - resp_base), 64'd1);
        if (!we && exp_code == 2'd0) exp_rdata = word;
        chk({tag, "_err"}, 64'(cap_err), 64'(exp_code != 2'd0));
        chk({tag, "_code"}, 64'(cap_code), 64'(exp_code));
        chk({tag, "_rdata"}, 64'(host_rdata_bo), 64'(exp_rdata));
        chk({tag, "_irq"}, 64'(irq_cnt - irq_base), 64'(exp_irq));
        if (silent) begin
            chk({tag, "_tmo_window"},
                64'((resp_cyc - c0) >= 16 && (resp_cyc - c0) <= 20), 64'd1);
        end
    endtask

    task automatic do_xfer(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] exp_code,
                           input int exp_irq, input logic [31:0] word, input bit inject);
        xfer_start(we, a, d, 1'b0, inject);
        xfer_finish(tag, we, exp_code, exp_irq, word, rx_q.size() == 0);
    endtask

    task automatic rand_xfer(input string tag);
        logic        we;
        logic [31:0] a, d, w;
        logic [1:0]  code;
        int          irqs;
        we = 1'($urandom_range(1));
        a = rand_word();
        d = rand_word();
        w = rand_word();
        irqs = 0;
        rx_q.delete();
        case ($urandom_range(3))
            0, 1: begin
                code = 2'd0;
                if (we) begin
                    add_noise(irqs);
                    rx_q.push_back(8'h00);
                end else begin
                    enc_read(w, irqs);
                end
            end
            2: begin
                code = 2'd1;
                add_noise(irqs);
                rx_q.push_back(8'h01);
            end
            default: begin
                code = 2'd2;
                add_noise(irqs);
                rx_q.push_back(8'h02);
            end
        endcase
        do_xfer(tag, we, a, d, code, irqs, w, 1'b0);
    endtask

    initial begin
        logic [7:0] wr_lit[$];
        logic [7:0] rd_lit[$];
        int okb, a0, rb, nt;
        wr_lit = '{8'h83, 8'h00, 8'h10, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rd_lit = '{8'h00, 8'h5A, 8'h5A, 8'hAA, 8'h5A, 8'h55};

        repeat (3) tick();
        chk("reset_outputs", 64'({host_ack_o, host_resp_o, host_err_o, host_err_code_bo,
                                  host_rdata_bo, irq_o, tx_dout_bo, tx_start_o}), 64'd0);
        reset_n_i = 1'b1;
        repeat (2) tick();

        rx_q = '{8'h00};
        do_xfer("wr_basic", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 0, 32'h0, 1'b0);
        okb = (last_tx.size() == wr_lit.size() + SO) ? 1 : 0;
        foreach (wr_lit[i]) if (okb == 1 && last_tx[SO + i] !== wr_lit[i]) okb = 0;
        chk("wr_basic_literal_frame", 64'(okb), 64'd1);

        rx_q = '{8'h5A, 8'h01, 8'h34, 8'h5A, 8'h5A, 8'h12};
        do_xfer("rd_esc", 1'b0, 32'h55AA_5A00, 32'h0, 2'd0, 0, 32'h125A_3401, 1'b0);
        okb = (last_tx.size() >= SO + 7) ? 1 : 0;
        foreach (rd_lit[i]) if (okb == 1 && last_tx[SO + 1 + i] !== rd_lit[i]) okb = 0;
        chk("rd_esc_addr_field", 64'(okb), 64'd1);
        chk("rd_esc_rdata_literal", 64'(host_rdata_bo), 64'h125A_3401);

        rx_q = '{8'h80, 8'h78, 8'h56, 8'h34, 8'h12};
        do_xfer("rd_irq", 1'b0, 32'h0000_0040, 32'h0, 2'd0, 1, 32'h1234_5678, 1'b0);

        rx_q = '{8'h01};
        do_xfer("wr_ackerr", 1'b1, 32'h0000_2000, 32'h0102_0304, 2'd1, 0, 32'h0, 1'b0);
        rx_q = '{8'h02};
        do_xfer("rd_resperr", 1'b0, 32'h0000_3000, 32'h0, 2'd2, 0, 32'h0, 1'b0);
        rx_q = '{8'h33};
        do_xfer("wr_baddata", 1'b1, 32'h0000_4000, 32'h1111_2222, 2'd3, 0, 32'h0, 1'b0);
        rx_q = '{8'h5A, 8'h00};
        do_xfer("wr_esc00", 1'b1, 32'h0000_5000, 32'h3333_4444, 2'd3, 0, 32'h0, 1'b0);

        rx_q = '{8'h00};
        do_xfer("wr_txdrop", 1'b1, 32'h0000_6000, 32'h5555_5A5A, 2'd0, 0, 32'h0, 1'b1);

        rx_q.delete();
        do_xfer("rd_addr0", 1'b0, 32'h0, 32'h0, 2'd3, 0, 32'h0, 1'b0);
`ifdef UDM_HOST_SYNC_EN
        chk("sync_first_byte", 64'(last_tx[0]), 64'h55);
`endif
        rand_xfer("after_tmo");

        a0 = ack_cnt;
        rx_q = '{8'h00};
        xfer_start(1'b1, 32'hCAFE_0000, 32'h0BAD_F00D, 1'b1, 1'b0);
        xfer_finish("hold1", 1'b1, 2'd0, 0, 32'h0, 1'b0);
        tick();
        chk("hold_reaccept", 64'(ack_cnt - a0), 64'd2);
        host_req_i = 1'b0;
        rx_q = '{8'h02};
        xfer_finish("hold2", 1'b1, 2'd2, 0, 32'h0, 1'b0);

        for (int i = 0; i < 16; i++) rand_xfer($sformatf("rnd%0d", i));

        rx_q.delete();
        xfer_start(1'b1, rand_word(), rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (tx_cap.size() >= 3) break;
            tick();
        end
        reset_n_i = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({host_ack_o, host_resp_o, host_err_o, host_err_code_bo,
                                    host_rdata_bo, irq_o, tx_dout_bo, tx_start_o}), 64'd0);
        exp_rdata = '0;
        rb = resp_cnt;
        nt = tx_cap.size();
        repeat (3) tick();
        reset_n_i = 1'b1;
        repeat (30) tick();
        chk("rst_no_resp", 64'(resp_cnt - rb), 64'd0);
        chk("rst_no_tx", 64'(tx_cap.size() - nt), 64'd0);
        rand_xfer("after_rst");

        chk("tx_start_while_busy", 64'(tx_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
